// File: rtl/dp_out_fifo_pkg.sv
// dp_out_fifo_pkg: shared sizing and lane helpers for the CPU output datapath
package dp_out_fifo_pkg;

    function automatic int lanes(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int lane_lo(input int lane, input int lane_w);
        return lane * lane_w;
    endfunction

endpackage

// File: rtl/dp_out_lane_mux.sv
// dp_out_lane_mux: one CPU lane choosing buffered head data or register data
module dp_out_lane_mux
    import dp_out_fifo_pkg::*;
#(
    parameter int LANE_W = 16
)(
    input  logic [LANE_W-1:0] i_head,
    input  logic [LANE_W-1:0] i_mod,
    input  logic              i_f2cpu,
    input  logic              i_s2cpu,
    output logic [LANE_W-1:0] o_data
);

    // full-width bypass beats the per-lane select
    always_comb o_data = (i_f2cpu && !i_s2cpu) ? i_head : i_mod;

endmodule

// File: rtl/dp_out_fifo.sv
// dp_out_fifo: buffered CPU output latch with lane bridging and MOD bypass
module dp_out_fifo
    import dp_out_fifo_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int LANE_W    = 16,
    parameter int DEPTH     = 2,
    parameter bit OVERWRITE = 1'b0,
    localparam int LANES    = lanes(DATA_W, LANE_W),
    localparam int CW       = $clog2(DEPTH + 1),
    localparam int PW       = ptr_w(DEPTH)
)(
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] OD,
    input  logic [DATA_W-1:0] MOD,
    input  logic              LOAD,
    input  logic              POP,
    input  logic              BRIDGEOUT,
    input  logic [LANES-1:0]  F2CPU,
    input  logic              S2CPU,
    output logic [DATA_W-1:0] DATA,
    output logic              EMPTY,
    output logic              FULL,
    output logic [CW-1:0]     COUNT,
    output logic              OVERRUN
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_last;
    logic [PW-1:0]     r_rd, r_wr;
    logic [CW-1:0]     r_count;
    logic              r_overrun;

    logic [DATA_W-1:0] w_entry, w_head;
    logic [PW-1:0]     w_rd_nxt, w_wr_nxt, w_wr_prev;
    logic              w_full, w_empty, w_push, w_pop, w_ovw, w_drop;

    assign w_full    = r_count == CW'(DEPTH);
    assign w_empty   = r_count == '0;
    // a pop on a full buffer frees the slot the simultaneous load lands in
    assign w_push    = LOAD && (!w_full || POP);
    assign w_pop     = POP && !w_empty;
    assign w_ovw     = LOAD && w_full && !POP && OVERWRITE;
    assign w_drop    = LOAD && w_full && !POP && !OVERWRITE;
    assign w_rd_nxt  = (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + PW'(1);
    assign w_wr_nxt  = (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + PW'(1);
    assign w_wr_prev = (r_wr == '0) ? PW'(DEPTH - 1) : r_wr - PW'(1);
    // once drained the lanes keep showing the last retired word, like the old latch
    assign w_head    = w_empty ? r_last : r_mem[r_rd];

    assign EMPTY   = w_empty;
    assign FULL    = w_full;
    assign COUNT   = r_count;
    assign OVERRUN = r_overrun;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign w_entry[lane_lo(i, LANE_W) +: LANE_W] =
            BRIDGEOUT ? OD[LANE_W-1:0] : OD[lane_lo(i, LANE_W) +: LANE_W];
        dp_out_lane_mux #(.LANE_W(LANE_W)) u_mux (
            .i_head  (w_head[lane_lo(i, LANE_W) +: LANE_W]),
            .i_mod   (MOD[lane_lo(i, LANE_W) +: LANE_W]),
            .i_f2cpu (F2CPU[i]),
            .i_s2cpu (S2CPU),
            .o_data  (DATA[lane_lo(i, LANE_W) +: LANE_W])
        );
    end

    // storage writes: append at the tail, or replace the youngest entry when overwriting
    always_ff @(posedge CLK) begin
        if (w_push)
            r_mem[r_wr] <= w_entry;
        else if (w_ovw)
            r_mem[w_wr_prev] <= w_entry;
    end

    // pointers, occupancy, hold register and sticky overrun
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rd      <= '0;
            r_wr      <= '0;
            r_count   <= '0;
            r_last    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push)
                r_wr <= w_wr_nxt;
            if (w_pop) begin
                r_rd   <= w_rd_nxt;
                r_last <= r_mem[r_rd];
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_drop)
                r_overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dp_out_fifo.sv
// tb_dp_out_fifo: scoreboard bench for both drop and overwrite flavours of dp_out_fifo
module tb_dp_out_fifo;

    logic        CLK = 1'b0;
    logic        RST, LOAD, POP, BRIDGEOUT, S2CPU;
    logic [31:0] OD, MOD;
    logic [1:0]  F2CPU;
    logic [31:0] data0, data1;
    logic        empty0, full0, ovr0, empty1, full1, ovr1;
    logic [1:0]  count0, count1;

    logic [31:0] q0[$], q1[$];
    logic [31:0] last0, last1;
    logic        movr0, movr1;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 CLK = ~CLK;

    dp_out_fifo #(.DATA_W(32), .LANE_W(16), .DEPTH(2), .OVERWRITE(1'b0)) u_drop (
        .CLK(CLK), .RST(RST), .OD(OD), .MOD(MOD), .LOAD(LOAD), .POP(POP),
        .BRIDGEOUT(BRIDGEOUT), .F2CPU(F2CPU), .S2CPU(S2CPU), .DATA(data0),
        .EMPTY(empty0), .FULL(full0), .COUNT(count0), .OVERRUN(ovr0)
    );

    dp_out_fifo #(.DATA_W(32), .LANE_W(16), .DEPTH(2), .OVERWRITE(1'b1)) u_ovw (
        .CLK(CLK), .RST(RST), .OD(OD), .MOD(MOD), .LOAD(LOAD), .POP(POP),
        .BRIDGEOUT(BRIDGEOUT), .F2CPU(F2CPU), .S2CPU(S2CPU), .DATA(data1),
        .EMPTY(empty1), .FULL(full1), .COUNT(count1), .OVERRUN(ovr1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [31:0] head);
        logic [31:0] r;
        r[15:0]  = (F2CPU[0] && !S2CPU) ? head[15:0]  : MOD[15:0];
        r[31:16] = (F2CPU[1] && !S2CPU) ? head[31:16] : MOD[31:16];
        return r;
    endfunction

    task automatic check_all();
        chk("data_drop", data0, exp_data(q0.size() != 0 ? q0[0] : last0));
        chk("data_ovw",  data1, exp_data(q1.size() != 0 ? q1[0] : last1));
        chk("count_drop", {30'd0, count0}, q0.size());
        chk("count_ovw",  {30'd0, count1}, q1.size());
        chk("empty_drop", {31'd0, empty0}, {31'd0, q0.size() == 0});
        chk("full_drop",  {31'd0, full0},  {31'd0, q0.size() == 2});
        chk("full_ovw",   {31'd0, full1},  {31'd0, q1.size() == 2});
        chk("ovr_drop",   {31'd0, ovr0},   {31'd0, movr0});
        chk("ovr_ovw",    {31'd0, ovr1},   1'b0);
    endtask

    task automatic step(input logic rst, input logic ld, input logic [31:0] od, input logic pp);
        logic [31:0] e;
        RST = rst; LOAD = ld; OD = od; POP = pp;
        @(posedge CLK);
        e = BRIDGEOUT ? {2{od[15:0]}} : od;
        if (rst) begin
            q0 = {}; q1 = {}; last0 = '0; last1 = '0; movr0 = 1'b0; movr1 = 1'b0;
        end else begin
            if (pp && q0.size() != 0) last0 = q0.pop_front();
            if (pp && q1.size() != 0) last1 = q1.pop_front();
            if (ld) begin
                if (q0.size() < 2) q0.push_back(e);
                else movr0 = 1'b1;
                if (q1.size() < 2) q1.push_back(e);
                else q1[$] = e;
            end
        end
        #1;
        RST = 1'b0; LOAD = 1'b0; POP = 1'b0;
        check_all();
    endtask

    initial begin
        RST = 1'b1; LOAD = 1'b0; POP = 1'b0; OD = '0; MOD = '0;
        BRIDGEOUT = 1'b0; F2CPU = 2'b11; S2CPU = 1'b0;
        step(1, 0, 0, 0);
        step(1, 1, 32'h99999999, 1);
        MOD = 32'hAAAA5555; #1;
        chk("rst_data_f11", data0, 32'h0);
        chk("rst_empty", {31'd0, empty0}, 1);
        chk("rst_count", {30'd0, count0}, 0);
        F2CPU = 2'b00; #1;
        chk("rst_data_f00", data0, 32'hAAAA5555);
        F2CPU = 2'b11;

        step(0, 1, 32'h11112222, 0);
        step(0, 1, 32'h33334444, 0);
        chk("fill_head", data0, 32'h11112222);
        chk("fill_full", {31'd0, full0}, 1);
        step(0, 0, 0, 1);
        chk("pop1_head", data0, 32'h33334444);
        step(0, 0, 0, 1);
        chk("pop2_empty", {31'd0, empty0}, 1);
        chk("pop2_hold", data0, 32'h33334444);
        step(0, 0, 0, 1);
        chk("pop_empty_hold", data0, 32'h33334444);

        step(1, 0, 0, 0);
        BRIDGEOUT = 1'b1;
        step(0, 1, 32'hDEADBEEF, 0);
        chk("bridge", data0, 32'hBEEFBEEF);
        F2CPU = 2'b01; MOD = 32'h12340000; #1;
        chk("bridge_mix", data0, 32'h1234BEEF);
        BRIDGEOUT = 1'b0; F2CPU = 2'b11;

        step(1, 0, 0, 0);
        step(0, 1, 32'h0000000A, 0);
        step(0, 1, 32'h0000000B, 0);
        step(0, 1, 32'hCAFEF00D, 0);
        chk("ovr_flag", {31'd0, ovr0}, 1);
        chk("ovr_count", {30'd0, count0}, 2);
        chk("ovr_head", data0, 32'h0000000A);
        chk("ovw_noflag", {31'd0, ovr1}, 0);
        step(0, 0, 0, 1);
        chk("ovw_second", data1, 32'hCAFEF00D);
        chk("drop_second", data0, 32'h0000000B);
        step(0, 0, 0, 1);
        chk("ovr_sticky", {31'd0, ovr0}, 1);

        step(1, 0, 0, 0);
        step(0, 1, 32'h1, 0);
        step(0, 1, 32'h2, 0);
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 32'h5 + k, 1);
            chk("lp_full_count", {30'd0, count0}, 2);
        end
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 1, 32'h77, 1);
        chk("lp_empty_count", {30'd0, count0}, 1);
        chk("lp_empty_head", data0, 32'h77);

        S2CPU = 1'b1; MOD = 32'h0BADCAFE; #1;
        chk("s2cpu", data0, 32'h0BADCAFE);
        S2CPU = 1'b0;

        for (int k = 0; k < 300; k++) begin
            MOD = $urandom; F2CPU = 2'($urandom); S2CPU = ($urandom_range(0, 7) == 0);
            BRIDGEOUT = $urandom_range(0, 1);
            step($urandom_range(0, 40) == 0, $urandom_range(0, 1), $urandom, $urandom_range(0, 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
